// File: rtl/conv_viterbi_pkg.sv
// Shared constants and branch-symbol helpers for the K=4 rate-1/2 convolutional codec.
package conv_viterbi_pkg;

  localparam int NUM_STATES = 8;
  localparam int K = 4;
  localparam logic [3:0] G1 = 4'b1111;
  localparam logic [3:0] G0 = 4'b1011;

  // Tap window ordered {u, s0, s1, s2}, newest bit first, to line up with the generators.
  function automatic logic [1:0] expected_symbol(input logic [2:0] state, input logic u);
    logic [3:0] w;
    w = {u, state[0], state[1], state[2]};
    return {^(w & G1), ^(w & G0)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/conv_encoder_k4.sv
// Registered K=4 rate-1/2 convolutional encoder; one symbol per enabled cycle.
module conv_encoder_k4
  import conv_viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_i,
  output logic       valid_o,
  output logic [1:0] d_o
);

  logic [2:0] state_q, state_d;
  logic [1:0] sym_q, sym_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    if (enable_i) begin
      sym_d   = expected_symbol(state_q, d_i);
      state_d = {state_q[1:0], d_i};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign d_o     = sym_q;

endmodule

// File: rtl/conv_viterbi_codec.sv
// Convolutional encoder plus hard-decision register-exchange Viterbi decoder.
// Optional error counter output enabled by defining VITERBI_ERRCNT_EN.
module conv_viterbi_codec
  import conv_viterbi_pkg::*;
#(
  parameter int TB_LEN = 24,
  parameter int PM_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_d_o,
  output logic       dec_valid_o
`ifdef VITERBI_ERRCNT_EN
  ,
  output logic [15:0] dec_errcnt_o
`endif
);

  localparam int CNT_W = $clog2(TB_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_LEN);
  // Non-zero start states are penalised so decoding assumes the encoder starts in state 0.
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + (PM_W+1)'(b);
    return s[PM_W] ? '1 : s[PM_W-1:0];
  endfunction

  conv_encoder_k4 u_enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_enable_i),
    .d_i      (enc_d_i),
    .valid_o  (enc_valid_o),
    .d_o      (enc_d_o)
  );

  logic [PM_W-1:0]   pm_q   [NUM_STATES];
  logic [PM_W-1:0]   pm_d   [NUM_STATES];
  logic [PM_W-1:0]   cand0  [NUM_STATES];
  logic [PM_W-1:0]   cand1  [NUM_STATES];
  logic [PM_W-1:0]   acs_pm [NUM_STATES];
  logic [TB_LEN-1:0] surv_q   [NUM_STATES];
  logic [TB_LEN-1:0] surv_d   [NUM_STATES];
  logic [TB_LEN-1:0] acs_surv [NUM_STATES];
  logic [PM_W-1:0]   min_pm;
  logic [2:0]        best;
  logic              dec_d_q, dec_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Predecessors of ns are ns>>1 (b=0) and (ns>>1)+4 (b=1); input bit is ns[0].
  always_comb begin
    for (int ns = 0; ns < NUM_STATES; ns++) begin
      cand0[ns] = sat_add(pm_q[ns >> 1],
                          hamming2(dec_d_i, expected_symbol(3'(ns >> 1), 1'(ns & 1))));
      cand1[ns] = sat_add(pm_q[(ns >> 1) + 4],
                          hamming2(dec_d_i, expected_symbol(3'((ns >> 1) + 4), 1'(ns & 1))));
      if (cand1[ns] < cand0[ns]) begin
        acs_pm[ns]   = cand1[ns];
        acs_surv[ns] = {surv_q[(ns >> 1) + 4][TB_LEN-2:0], 1'(ns & 1)};
      end else begin
        acs_pm[ns]   = cand0[ns];
        acs_surv[ns] = {surv_q[ns >> 1][TB_LEN-2:0], 1'(ns & 1)};
      end
    end
    min_pm = acs_pm[0];
    best   = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (acs_pm[s] < min_pm) begin
        min_pm = acs_pm[s];
        best   = 3'(s);
      end
    end
  end

  always_comb begin
    pm_d    = pm_q;
    surv_d  = surv_q;
    dec_d_d = dec_d_q;
    cnt_d   = cnt_q;
    if (dec_enable_i) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_d[s] = acs_pm[s] - min_pm;
      end
      surv_d  = acs_surv;
      dec_d_d = acs_surv[best][TB_LEN-1];
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_q[i] <= '0;
      end
      dec_d_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pm_q    <= pm_d;
      surv_q  <= surv_d;
      dec_d_q <= dec_d_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dec_d_o     = dec_d_q;
  assign dec_valid_o = (cnt_q == CNT_MAX);

`ifdef VITERBI_ERRCNT_EN
  logic [15:0] errcnt_q, errcnt_d;
  logic [16:0] errcnt_sum;

  // The pre-normalisation minimum is exactly the cost added to the best path this symbol.
  always_comb begin
    errcnt_sum = {1'b0, errcnt_q} + 17'(min_pm);
    errcnt_d   = errcnt_q;
    if (dec_enable_i) errcnt_d = errcnt_sum[16] ? 16'hFFFF : errcnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) errcnt_q <= '0;
    else      errcnt_q <= errcnt_d;
  end

  assign dec_errcnt_o = errcnt_q;
`endif

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Self-checking bench for conv_viterbi_codec: encoder/decoder loopback with a behavioural model.
module tb_conv_viterbi_codec;

  localparam int TB_LEN = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_i = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i = 1'b0;
  logic [1:0] dec_d_i = 2'b00;
  logic       dec_d_o;
  logic       dec_valid_o;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] dec_errcnt_o;
`endif

  always #5 clk = ~clk;

  conv_viterbi_codec #(.TB_LEN(TB_LEN), .PM_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_d_o      (dec_d_o),
    .dec_valid_o  (dec_valid_o)
`ifdef VITERBI_ERRCNT_EN
    ,
    .dec_errcnt_o (dec_errcnt_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model state: every bit the encoder accepted since reset, and decoder accept count.
  logic       sent [2048];
  int         n_sent;
  int         n_acc;
  logic       prev_en;
  logic [1:0] exp_enc;
  int         err_mode;
  int         flips;

  task automatic check1(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bit_at(input int i);
    return (i >= 0) ? int'(sent[i]) : 0;
  endfunction

  // Symbol for the n-th encoded bit: g1 = parity of last four inputs, g0 skips the 2nd newest.
  function automatic logic [1:0] model_sym(input int n);
    int g1, g0;
    g1 = bit_at(n-1) ^ bit_at(n-2) ^ bit_at(n-3) ^ bit_at(n-4);
    g0 = bit_at(n-1) ^ bit_at(n-3) ^ bit_at(n-4);
    return {1'(g1), 1'(g0)};
  endfunction

  function automatic logic [1:0] err_pattern(input int idx);
    logic [1:0] f;
    f = 2'b00;
    case (err_mode)
      1: if (idx % 64 == 10) f = ((idx / 64) % 2 == 1) ? 2'b10 : 2'b01;
      2: if (idx % 64 == 20) f = 2'b11;
      3: begin
        if (idx % 64 == 30) f = 2'b01;
        if (idx % 64 == 31) f = 2'b10;
      end
      default: f = 2'b00;
    endcase
    return f;
  endfunction

  // One clock: check what the last edge produced, then drive the next cycle's inputs.
  task automatic cycle(input logic en, input logic d);
    logic [1:0] flip;
    @(negedge clk);
    if (dec_enable_i) n_acc++;
    if (prev_en) exp_enc = model_sym(n_sent);
    check1("enc_valid", int'(enc_valid_o), int'(prev_en));
    check1("enc_d", int'(enc_d_o), int'(exp_enc));
    check1("dec_valid", int'(dec_valid_o), (n_acc >= TB_LEN) ? 1 : 0);
    check1("dec_d", int'(dec_d_o), (n_acc >= TB_LEN) ? int'(sent[n_acc-TB_LEN]) : 0);
    flip = enc_valid_o ? err_pattern(n_acc) : 2'b00;
    flips += int'(flip[0]) + int'(flip[1]);
    dec_d_i      = enc_d_o ^ flip;
    dec_enable_i = enc_valid_o;
    enc_enable_i = en;
    enc_d_i      = d;
    prev_en      = en;
    if (en) begin
      sent[n_sent] = d;
      n_sent++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_i = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i = 2'b00;
    #1;
    check1("rst_enc_valid", int'(enc_valid_o), 0);
    check1("rst_enc_d", int'(enc_d_o), 0);
    check1("rst_dec_d", int'(dec_d_o), 0);
    check1("rst_dec_valid", int'(dec_valid_o), 0);
`ifdef VITERBI_ERRCNT_EN
    check1("rst_errcnt", int'(dec_errcnt_o), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_sent = 0;
    n_acc = 0;
    prev_en = 1'b0;
    exp_enc = 2'b00;
    flips = 0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic run_stream(input int n, input bit gaps);
    logic [15:0] lfsr;
    logic        en;
    lfsr = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      en = gaps ? ((i % 7 != 3) && (i % 11 != 5) && (i % 13 != 8)) : 1'b1;
      cycle(en, lfsr[0]);
      if (en) lfsr = lfsr_next(lfsr);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] impulse_exp [6];
    impulse_exp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    n_sent = 0; n_acc = 0; prev_en = 1'b0; exp_enc = 2'b00; err_mode = 0; flips = 0;

    // Impulse response pinned against literal symbols.
    apply_reset();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0);
      check1("impulse_sym", int'(enc_d_o), int'(impulse_exp[i]));
      check1("impulse_valid", int'(enc_valid_o), 1);
    end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check1("impulse_valid_drop", int'(enc_valid_o), 0);
    check1("impulse_hold", int'(enc_d_o), 0);

    // Clean loopback.
    apply_reset();
    err_mode = 0;
    run_stream(256, 1'b0);
    check1("clean_accepts", n_acc, 256);
`ifdef VITERBI_ERRCNT_EN
    check1("clean_errcnt", int'(dec_errcnt_o), 0);
`endif

    // Isolated single-bit errors.
    apply_reset();
    err_mode = 1;
    run_stream(256, 1'b0);
    check1("single_flips", flips, 4);
`ifdef VITERBI_ERRCNT_EN
    check1("single_errcnt", int'(dec_errcnt_o), flips);
`endif

    // Both bits of one symbol.
    apply_reset();
    err_mode = 2;
    run_stream(256, 1'b0);

    // One bit in each of two consecutive symbols.
    apply_reset();
    err_mode = 3;
    run_stream(256, 1'b0);

    // Enable gaps on both paths.
    apply_reset();
    err_mode = 0;
    run_stream(300, 1'b1);

    // Reset mid-stream, then resend.
    apply_reset();
    err_mode = 0;
    run_stream(100, 1'b0);
    apply_reset();
    run_stream(256, 1'b0);
    check1("restart_accepts", n_acc, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_viterbi_codec.md
Name: conv_viterbi_codec

Overview:
- Rate-1/2, constraint-length-4 (8-state) convolutional encoder paired with a hard-decision Viterbi decoder using register-exchange survivors.
- Encoder path and decoder path are independent; the channel or error-injection logic sits between them outside this block.
- The decoder recovers the encoder input stream with a fixed latency, correcting isolated 1- and 2-bit symbol errors.

Parameters:
- TB_LEN, 24: survivor (register-exchange) depth in bits; sets decoder latency. Minimum 8.
- PM_W, 6: path-metric width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enc_enable_i  in  1  encoder accepts enc_d_i this cycle.
- enc_d_i  in  1  encoder data bit.
- enc_valid_o  out  1  enc_d_o carries a new symbol.
- enc_d_o  out  2  encoded symbol {g1,g0}.
- dec_enable_i  in  1  decoder accepts dec_d_i this cycle.
- dec_d_i  in  2  received hard-decision symbol {g1,g0}.
- dec_d_o  out  1  decoded bit.
- dec_valid_o  out  1  high once TB_LEN symbols have been accepted since reset.

Behaviour:
- Reset clears everything: encoder state s[2:0]=0, enc_valid_o=0, enc_d_o=0, dec_d_o=0, dec_valid_o=0, all survivors 0.
- Reset path metrics: PM[0]=0; PM[1..7]=2^(PM_W-2).
- Encoder (registered, 1-cycle latency). When enc_enable_i=1:
  - enc_d_o[1] <= u^s0^s1^s2 (generator 1111).
  - enc_d_o[0] <= u^s1^s2 (generator 1011).
  - s <= {s1,s0,u}, where u=enc_d_i.
  - enc_valid_o <= 1.
- Encoder when enc_enable_i=0: state and enc_d_o hold; enc_valid_o <= 0.
- Decoder state indexing matches the encoder: next state ns={s1,s0,u}. The predecessors of ns are {b,ns[2:1]} for b in {0,1}, with input bit u=ns[0].
- Branch metric: Hamming distance (0..2) between dec_d_i and the expected symbol for that transition.
- Add-compare-select per ns:
  - Candidate = PM[pred]+BM, saturating at 2^PM_W-1.
  - Keep the smaller candidate; on a tie keep pred with b=0.
  - New survivor = {surv[pred][TB_LEN-2:0], u}.
- Normalization: find min over the 8 new metrics and the best state (lowest index on ties). Store PM[ns] <= new-min, so the best state always holds 0.
- Output: dec_d_o <= new surv[best][TB_LEN-1] (oldest bit).
- Latency: the bit of the n-th accepted symbol is on dec_d_o after the clock edge accepting symbol n+TB_LEN-1. With continuous enable, the encoder bit entered at cycle t appears at dec_d_o at cycle t+TB_LEN+1 through the encoder register.
- dec_valid_o rises on the edge accepting the TB_LEN-th symbol and stays high until reset. Use a saturating counter.
- When dec_enable_i=0, all decoder state and outputs hold. Gaps in enable do not change decoded content.
- Reset asserted mid-stream immediately restores reset values; decoding restarts assuming encoder state 0.

Optional Feature:
- Macro VITERBI_ERRCNT_EN.
- Defined: adds output dec_errcnt_o (16 bits, reset 0). On each accepted symbol it adds the pre-normalization min metric increment, i.e. channel bit errors charged to the best path. Saturates at 16'hFFFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package conv_viterbi_pkg holds:
  - NUM_STATES=8, K=4, G1=4'b1111, G0=4'b1011;
  - function expected_symbol(state,u) returning 2 bits;
  - function hamming2(a,b).
- One sub-module, conv_encoder_k4, is natural. It is instantiated once for the encoder path. The decoder uses the package function for branch symbols.

Test Plan:
- Impulse: reset, then enc_d_i=1 once followed by zeros, continuous enable → enc_d_o sequence 11,10,11,11,00,00…, enc_valid_o high one cycle after enable.
- Loopback clean: 256 pseudo-random bits (LFSR, seed 0xACE1) through the encoder into the decoder, no errors → dec_d_o equals input delayed TB_LEN+1 cycles, zero mismatches. With VITERBI_ERRCNT_EN, dec_errcnt_o=0.
- Single errors: flip one bit of every 64th symbol → zero decoded mismatches. dec_errcnt_o equals the number of flipped bits.
- Double error: flip both bits of one symbol, or one bit in two consecutive symbols, every 64th symbol → zero decoded mismatches.
- Enable gaps: deassert enc_enable_i and dec_enable_i on random cycles (same pattern delayed one cycle) → decoded stream equal to input stream; outputs hold during gaps.
- Reset mid-stream: assert rst at symbol 100, release, resend stream → all outputs 0 during reset, dec_valid_o low until TB_LEN new symbols, then correct decoding.
